// File: rtl/alu_pkg.sv
// Shared opcode encodings, FSM state encoding and flag bundle for alu_seq.
package alu_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_NOT = 3'b100;
  localparam logic [2:0] OP_XOR = 3'b101;
  localparam logic [2:0] OP_SHL = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  typedef struct packed {
    logic z;
    logic c;
    logic n;
    logic v;
  } flags_t;

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier: one multiplier bit per cycle, WIDTH cycles per product.
// Not stallable; o_done pulses on the final step with o_prod already including that step.
module alu_mul_iter #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_start,
  input  logic [WIDTH-1:0]     i_a,
  input  logic [WIDTH-1:0]     i_b,
  output logic                 o_done,
  output logic [2*WIDTH-1:0]   o_prod
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  logic [2*WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0]   r_mplier;
  logic [2*WIDTH-1:0] r_acc;
  logic [CNT_W-1:0]   r_cnt;

  logic [2*WIDTH-1:0] w_step;
  logic [2*WIDTH-1:0] w_acc_nxt;

  assign w_step    = r_mplier[0] ? r_mcand : '0;
  assign w_acc_nxt = r_acc + w_step;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
    end else if (i_start) begin
      r_mcand  <= {{WIDTH{1'b0}}, i_a};
      r_mplier <= i_b;
      r_acc    <= '0;
      r_cnt    <= CNT_W'(WIDTH);
    end else if (r_cnt != '0) begin
      r_acc    <= w_acc_nxt;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt - CNT_W'(1);
    end
  end

  // Last step: the consumer registers w_acc_nxt directly, so no extra cycle.
  assign o_done = (r_cnt == CNT_W'(1));
  assign o_prod = w_acc_nxt;

endmodule

// File: rtl/alu_seq.sv
// Registered ALU with valid/ready on both sides; latency 1 (single-cycle ops) or WIDTH (MUL).
// Result and flags hold while out_valid && !out_ready; a new op loads in the same cycle the old one drains.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       alu_sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] alu_out,
  output logic             flag_z,
  output logic             flag_c,
  output logic             flag_n,
  output logic             flag_v
);

  localparam int SH_W = $clog2(WIDTH);

  state_t           r_state;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_alu_out;
  flags_t           r_flags;

  logic             w_in_ready;
  logic             w_accept;
  logic             w_mul_start;
  logic             w_mul_done;
  logic [2*WIDTH-1:0] w_prod;

  logic [WIDTH:0]   w_add;
  logic [WIDTH:0]   w_sub;
  logic [WIDTH:0]   w_shl;
  logic [SH_W-1:0]  w_sh_amt;
  logic [WIDTH-1:0] w_res;
  flags_t           w_flg;
  logic [WIDTH-1:0] w_mul_res;
  flags_t           w_mul_flg;

  assign w_in_ready  = (r_state == ST_IDLE) || ((r_state == ST_HOLD) && out_ready);
  assign w_accept    = in_valid && w_in_ready;
  assign w_mul_start = w_accept && (alu_sel == OP_MUL);

  assign w_add    = {1'b0, a} + {1'b0, b};
  assign w_sub    = {1'b0, a} - {1'b0, b};
  assign w_sh_amt = b[SH_W-1:0];
  // Bit WIDTH of the widened shift is the last bit shifted out (0 for a zero shift).
  assign w_shl    = {1'b0, a} << w_sh_amt;

  always_comb begin
    w_res = '0;
    w_flg = '0;
    case (alu_sel)
      OP_ADD: begin
        w_res   = w_add[WIDTH-1:0];
        w_flg.c = w_add[WIDTH];
        w_flg.v = (a[WIDTH-1] == b[WIDTH-1]) && (w_add[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        w_res   = w_sub[WIDTH-1:0];
        w_flg.c = w_sub[WIDTH];
        w_flg.v = (a[WIDTH-1] != b[WIDTH-1]) && (w_sub[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND: w_res = a & b;
      OP_OR:  w_res = a | b;
      OP_NOT: w_res = ~a;
      OP_XOR: w_res = a ^ b;
      OP_SHL: begin
        w_res   = w_shl[WIDTH-1:0];
        w_flg.c = w_shl[WIDTH];
      end
      default: w_res = '0;
    endcase
    w_flg.z = (w_res == '0);
    w_flg.n = w_res[WIDTH-1];
  end

  always_comb begin
    w_mul_res   = w_prod[WIDTH-1:0];
    w_mul_flg   = '0;
    w_mul_flg.z = (w_mul_res == '0);
    w_mul_flg.c = |w_prod[2*WIDTH-1:WIDTH];
    w_mul_flg.n = w_mul_res[WIDTH-1];
  end

  alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_start (w_mul_start),
    .i_a     (a),
    .i_b     (b),
    .o_done  (w_mul_done),
    .o_prod  (w_prod)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_out_valid <= 1'b0;
      r_alu_out   <= '0;
      r_flags     <= '0;
    end else begin
      case (r_state)
        ST_IDLE, ST_HOLD: begin
          if (w_accept) begin
            if (alu_sel == OP_MUL) begin
              r_state     <= ST_BUSY;
              r_out_valid <= 1'b0;
            end else begin
              r_state     <= ST_HOLD;
              r_out_valid <= 1'b1;
              r_alu_out   <= w_res;
              r_flags     <= w_flg;
            end
          end else if ((r_state == ST_HOLD) && out_ready) begin
            r_state     <= ST_IDLE;
            r_out_valid <= 1'b0;
          end
        end
        ST_BUSY: begin
          if (w_mul_done) begin
            r_state     <= ST_HOLD;
            r_out_valid <= 1'b1;
            r_alu_out   <= w_mul_res;
            r_flags     <= w_mul_flg;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = r_out_valid;
  assign alu_out   = r_alu_out;
  assign flag_z    = r_flags.z;
  assign flag_c    = r_flags.c;
  assign flag_n    = r_flags.n;
  assign flag_v    = r_flags.v;

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Registered, parametrised successor to the team's 4-bit combinational ALU.
- Same 3-bit opcode space, retained encodings for ADD/SUB/AND/OR/NOT; adds XOR, SHL and an iterative shift-add MUL.
- Valid/ready handshake on input and output; one operation in flight; status flags registered with result.
- Sits between an operand-issue stage and a result consumer in the datapath.

Parameters:
- WIDTH, 8, operand/result width; power of two, >= 4.
- CNT_W, $clog2(WIDTH)+1, derived localparam: MUL iteration counter width.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands/opcode valid
- in_ready  output  1  block can accept an operation this cycle
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- alu_sel  input  3  opcode: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 NOT(A), 101 XOR, 110 SHL, 111 MUL
- out_valid  output  1  result/flags valid
- out_ready  input  1  consumer takes result
- alu_out  output  WIDTH  result
- flag_z  output  1  alu_out == 0
- flag_c  output  1  carry/borrow/shift-out/MUL high-half-nonzero
- flag_n  output  1  alu_out[WIDTH-1]
- flag_v  output  1  signed overflow (ADD/SUB only)

Behaviour:
- Reset (async, rst_n low): state IDLE; in_ready=1; out_valid=0; alu_out=0; all flags 0; counter and MUL accumulator 0. Deassertion takes effect synchronously to clk.
- FSM states: IDLE, BUSY, HOLD.
- Accept: in_valid && in_ready at a rising edge.
- in_ready = (state==IDLE) || (state==HOLD && out_ready). Back-to-back throughput is 1 op/cycle for single-cycle ops.
- Single-cycle ops (000-110): on accept, result and flags are registered; state -> HOLD; out_valid=1 the cycle after accept (latency 1).
- MUL (111): on accept, latch a, b and clear the 2*WIDTH accumulator; counter=WIDTH; state -> BUSY. Each BUSY cycle does one shift-add step and decrements the counter. When the counter reaches 0, state -> HOLD, with out_valid=1 exactly WIDTH cycles after the accept edge.
- HOLD: alu_out and flags stay stable while out_valid && !out_ready.
  - out_ready=1 and a new accept in the same cycle: load the new op (HOLD->HOLD for single-cycle, HOLD->BUSY for MUL).
  - out_ready=1 and no accept: out_valid=0, state -> IDLE; alu_out and flags keep their last value.
- in_valid is ignored in BUSY (in_ready=0). Inputs are sampled only at the accept edge; later changes have no effect.
- Arithmetic (all unsigned modulo 2^WIDTH for alu_out):
  - ADD: flag_c = carry-out; flag_v = sign(a)==sign(b) && sign(sum)!=sign(a).
  - SUB: a-b; flag_c = borrow (1 iff a<b unsigned); flag_v = sign(a)!=sign(b) && sign(diff)!=sign(a).
  - AND, OR, XOR, NOT(A, b ignored): flag_c=0, flag_v=0.
  - SHL: shift by b[$clog2(WIDTH)-1:0], upper bits of b ignored. flag_c = last bit shifted out; 0 when shift amount is 0. flag_v=0.
  - MUL: alu_out = low WIDTH bits of a*b; flag_c = (high WIDTH bits != 0); flag_v=0.
- flag_z and flag_n are always derived from the registered alu_out.
- Reset mid-MUL: the op is discarded; no out_valid is produced for it.

Decomposition:
- Package alu_pkg holds the opcode constants (OP_ADD..OP_MUL), the FSM state encoding, and a flags struct/typedef (z, c, n, v).
- One sub-module: alu_mul_iter (shift-add multiplier with start/busy/done and a WIDTH-cycle count). The top holds the FSM, handshake, combinational single-cycle ops and the flag logic.

Test Plan (WIDTH=8):
- Reset release, then ADD a=0x05 b=0x03 with out_ready=1 -> next cycle out_valid=1, alu_out=0x08, z=0 c=0 n=0 v=0. ADD 0x7F+0x01 -> 0x80, n=1, v=1. ADD 0xFF+0x01 -> 0x00, z=1, c=1.
- SUB 0x05-0x03 -> 0x02, c=0. SUB 0x03-0x05 -> 0xFE, c=1, n=1. AND 0x05,0x03 -> 0x01. OR -> 0x07. XOR -> 0x06. NOT a=0x05 -> 0xFA.
- SHL a=0x81 b=0x01 -> 0x02, c=1. SHL a=0x81 b=0x09 (amount 1) -> 0x02, c=1. b=0x00 -> 0x81, c=0.
- MUL 0x0F*0x11 -> out_valid exactly 8 cycles after accept, alu_out=0xFF, c=0, in_ready=0 throughout BUSY. MUL 0x10*0x10 -> 0x00, z=1, c=1.
- Backpressure: out_ready=0 for 5 cycles after an ADD -> alu_out/flags stable, in_ready=0. Then out_ready=1 with in_valid=1 (SUB) in the same cycle -> ADD consumed, SUB result valid the next cycle, no bubble.
- rst_n pulsed low 3 cycles into a MUL -> out_valid=0 and alu_out=0 immediately (async). After release, in_ready=1 and no stale MUL result appears.
